// File: rtl/key_pkg.sv
// Shared types and defaults for the key event scanner.
package key_pkg;

  localparam int KEYS_DEF  = 61;
  localparam int KEY_IDX_W = $clog2(KEYS_DEF);

  typedef struct packed {
    logic [KEY_IDX_W-1:0] key;
    logic                 press;
  } key_evt_t;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } scan_state_e;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous count-based event FIFO with registered head outputs (valid/data).
module key_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q, rd_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [W-1:0]  head_n;
  logic          pop, push_ok;

  // Full is judged on the count at the start of the cycle, before any pop.
  assign push_ok = push_i & (cnt_q != CW'(DEPTH));
  assign pop     = valid_o & ready_i;

  always_comb begin
    rd_n  = rd_q + AW'(pop);
    cnt_n = cnt_q + CW'(push_ok) - CW'(pop);
    // A push landing on the new head slot bypasses the array.
    head_n = (push_ok && (rd_n == wr_q)) ? data_i : mem[rd_n];
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push_ok);
      rd_q    <= rd_n;
      cnt_q   <= cnt_n;
      valid_o <= (cnt_n != '0);
      data_o  <= head_n;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/key_event_scanner.sv
// Round-robin key change scanner feeding an event FIFO.
// Define KEY_EVT_LEVEL_EN to expose the FIFO occupancy on evt_level_o.
module key_event_scanner
  import key_pkg::*;
#(
  parameter int KEYS       = KEYS_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    scan_en_i,
  input  logic [KEYS-1:0]         keys_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [$clog2(KEYS)-1:0] evt_key_o,
  output logic                    evt_press_o,
  output logic                    scan_wrap_o
`ifdef KEY_EVT_LEVEL_EN
  ,output logic [$clog2(FIFO_DEPTH):0] evt_level_o
`endif
);

  localparam int IW = $clog2(KEYS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(KEYS - 1);

  scan_state_e   state_q, state_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [KEYS-1:0] prev_q;
  logic          wrap_q;
  logic          cur, chg, adv, push, full;
  logic [CW-1:0] fifo_cnt;
  logic [IW:0]   fifo_head;

  assign full = (fifo_cnt == CW'(FIFO_DEPTH));

  always_comb begin
    state_n = state_q;
    adv     = 1'b0;
    push    = 1'b0;
    cur     = keys_i[idx_q];
    chg     = cur ^ prev_q[idx_q];
    unique case (state_q)
      SCAN: if (scan_en_i) begin
        if (!chg) adv = 1'b1;
        else if (!full) begin
          push = 1'b1;
          adv  = 1'b1;
        end else state_n = HOLD;
      end
      // Return without advancing so the key is sampled again.
      HOLD: if (scan_en_i && !full) state_n = SCAN;
      default: state_n = SCAN;
    endcase
    idx_n = adv ? ((idx_q == LAST) ? '0 : idx_q + 1'b1) : idx_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SCAN;
      idx_q   <= '0;
      prev_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      wrap_q  <= adv && (idx_q == LAST);
      if (push) prev_q[idx_q] <= cur;
    end
  end

  key_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(IW + 1)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  ({idx_q, cur}),
    .ready_i (evt_ready_i),
    .valid_o (evt_valid_o),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign evt_key_o   = fifo_head[IW:1];
  assign evt_press_o = fifo_head[0];
  assign scan_wrap_o = wrap_q;
`ifdef KEY_EVT_LEVEL_EN
  assign evt_level_o = fifo_cnt;
`endif

endmodule

// File: doc/key_event_scanner.md
KEY_EVENT_SCANNER -- requirements
Module: key_event_scanner

Interface
REQ-001 SHALL have parameter KEYS, default 61, meaning number of debounced key inputs scanned.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk_i input 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni input 1, reset: synchronous, active-low.
REQ-005 SHALL have port scan_en_i input 1, scan enable; 0 freezes the scan pointer and snapshot.
REQ-006 SHALL have port keys_i input KEYS, debounced key levels (1 = pressed).
REQ-007 SHALL have port evt_valid_o output 1, head event available.
REQ-008 SHALL have port evt_ready_i input 1, consumer accepts head event.
REQ-009 SHALL have port evt_key_o output $clog2(KEYS), key index of head event.
REQ-010 SHALL have port evt_press_o output 1, 1 = press, 0 = release.
REQ-011 SHALL have port scan_wrap_o output 1, one-cycle pulse when the pointer wraps from KEYS-1 to 0.

Function
REQ-012 SHALL hold snapshot register prev[KEYS-1:0] plus scan pointer idx in 0..KEYS-1.
REQ-013 SHALL implement FSM states SCAN and HOLD.
REQ-014 In SCAN with scan_en_i=1: if keys_i[idx]==prev[idx], idx advances by one.
REQ-015 In SCAN with scan_en_i=1: if keys_i[idx]!=prev[idx] and FIFO not full, push {idx, keys_i[idx]}, set prev[idx]<=keys_i[idx], and advance idx.
REQ-016 In SCAN: if a change is present and the FIFO is full, enter HOLD with idx unchanged and no push.
REQ-017 In HOLD: stay until the FIFO is not full, then return to SCAN without advancing; the key is re-sampled there, so a change that reverted meanwhile produces no event.
REQ-018 Full SHALL be evaluated before any same-cycle pop: push is allowed only when count<FIFO_DEPTH at the start of the cycle.
REQ-019 Pointer wrap-around: from KEYS-1, advance goes to 0 and scan_wrap_o pulses 1 for that cycle.
REQ-020 Events SHALL never be dropped or duplicated; at most one push per cycle.
REQ-021 The FIFO SHALL pop on evt_valid_o & evt_ready_i; simultaneous push and pop SHALL leave count unchanged.
REQ-022 evt_valid_o/evt_key_o/evt_press_o SHALL be registered FIFO-head outputs; latency from push to evt_valid_o=1 on an empty FIFO is 1 cycle.
REQ-023 evt_key_o/evt_press_o SHALL be stable while evt_valid_o=1 and evt_ready_i=0.
REQ-024 Worst-case detection latency (FIFO not full) SHALL be KEYS cycles from a keys_i change to push.
REQ-025 With scan_en_i=0: no push and no pointer move; pops continue; scan_wrap_o=0; an FSM in HOLD stays in HOLD.

Reset
REQ-026 When rst_ni=0 at a clock edge: prev=0, idx=0, state=SCAN, FIFO empty, evt_valid_o=0, evt_key_o=0, evt_press_o=0, scan_wrap_o=0.
REQ-027 Reset mid-operation SHALL discard queued events; keys still held after reset generate fresh press events.

Configuration
REQ-028 Macro KEY_EVT_LEVEL_EN: when defined, add output evt_level_o [$clog2(FIFO_DEPTH):0], the registered FIFO occupancy (0 at reset).
REQ-029 When KEY_EVT_LEVEL_EN is not defined, the port SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package key_pkg SHALL hold the KEYS default, KEY_IDX_W=$clog2(KEYS), the event record typedef key_evt_t {key, press}, and the FSM state encoding.
REQ-031 The FIFO SHALL be sub-module key_evt_fifo (synchronous, count-based full/empty); the scanner FSM SHALL stay in key_event_scanner.

Verification
REQ-032 Reset with keys_i=0, scan_en_i=1, run 61 cycles -> no events; scan_wrap_o pulses every 61 cycles.
REQ-033 Set keys_i[5]=1, evt_ready_i=1 -> exactly one event {key=5, press=1}; clear keys_i[5] -> one event {5, 0}.
REQ-034 Hold evt_ready_i=0, press keys 0..9 -> 8 events queued, FSM in HOLD at idx 8; release evt_ready_i -> events 0..9 emerge in order, none lost.
REQ-035 FIFO full in HOLD at key 8, revert keys_i[8] before draining -> no event for key 8; key 9 event still produced.
REQ-036 Press key 60 at idx 60 with simultaneous pop of a full FIFO -> push blocked this cycle (REQ-018), event emitted later; wrap to idx 0 pulses scan_wrap_o.
REQ-037 Assert rst_ni=0 for one cycle with 4 queued events and keys 3 and 7 held -> FIFO empty; after reset, events {3,1} then {7,1}.
